mode_counter: RTL and testbench

MODE_COUNTER -- requirements
Module: mode_counter

---
 rtl/mode_counter_if.sv | 25 ++
 rtl/mode_counter.sv | 94 +++++++++
 tb/tb_mode_counter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mode_counter_if.sv
// Control/status bundle for mode_counter: step controls in, count and flags out.
interface mode_counter_if #(
    parameter int Width = 8
);
    logic             enable;
    logic             up;
    logic [1:0]       mode;
    logic [Width-1:0] limit;
    logic             load;
    logic [Width-1:0] load_value;
    logic             start;
    logic [Width-1:0] count;
    logic             tc;
    logic             busy;

    modport master (
        output enable, up, mode, limit, load, load_value, start,
        input  count, tc, busy
    );

    modport slave (
        input  enable, up, mode, limit, load, load_value, start,
        output count, tc, busy
    );
endinterface

// File: rtl/mode_counter.sv
// Up/down counter with wrap, saturate, one-shot and hold modes plus a
// registered terminal-count flag; the one-shot run is a two-state FSM.
module mode_counter #(
    parameter int Width = 8
) (
    input  logic           clk,
    input  logic           reset,
    mode_counter_if.slave  bus
);
    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;
    localparam logic [Width-1:0] ONE = Width'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [Width-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             term;

    // Non-terminal step in the selected direction, modulo 2^Width.
    function automatic logic [Width-1:0] step_val(input logic [Width-1:0] c,
                                                   input logic dir_up);
        return dir_up ? c + ONE : c - ONE;
    endfunction

    // Count above limit while counting up is treated as terminal.
    assign term = bus.up ? (count_q >= bus.limit) : (count_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;

        if (bus.load) begin
            count_d = bus.load_value;
        end else begin
            unique case (bus.mode)
                MODE_WRAP: begin
                    if (bus.enable) begin
                        if (term) begin
                            count_d = bus.up ? '0 : bus.limit;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = step_val(count_q, bus.up);
                        end
                    end
                end
                MODE_SAT: begin
                    if (bus.enable) begin
                        if (term) tc_d = 1'b1;
                        else      count_d = step_val(count_q, bus.up);
                    end
                end
                MODE_ONE: begin
                    if (state_q == IDLE) begin
                        if (bus.start) begin
                            count_d = bus.up ? '0 : bus.limit;
                            state_d = RUN;
                        end
                    end else if (bus.enable) begin
                        if (term) begin
                            tc_d    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            count_d = step_val(count_q, bus.up);
                        end
                    end
                end
                default: ;
            endcase
        end

        // The one-shot FSM only lives while mode selects it.
        if (bus.mode != MODE_ONE) state_d = IDLE;
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = (state_q == RUN);
endmodule

// File: tb/tb_mode_counter.sv
// Directed test of mode_counter: every expected value is worked out by hand.
module tb_mode_counter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mode_counter_if #(.Width(8)) bus ();

    mode_counter #(.Width(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] c,
                              input logic t, input logic b);
        check_eq({tag, ".count"}, 32'(bus.count), 32'(c));
        check_eq({tag, ".tc"},    32'(bus.tc),    32'(t));
        check_eq({tag, ".busy"},  32'(bus.busy),  32'(b));
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.load = 1'b1; bus.load_value = v;
        cyc();
        bus.load = 1'b0;
    endtask

    logic [7:0] wrap_cnt [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
    logic       wrap_tc  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.enable = 1'b1; bus.up = 1'b1; bus.mode = 2'b10; bus.limit = 8'd5;
        bus.load = 1'b1; bus.load_value = 8'hAA; bus.start = 1'b1;
        cyc(); cyc();
        expect_out("reset", 8'd0, 1'b0, 1'b0);

        // Wrap up, limit 5
        bus.load = 1'b0; bus.start = 1'b0; bus.mode = 2'b00;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            expect_out($sformatf("wrap_up%0d", i), wrap_cnt[i], wrap_tc[i], 1'b0);
        end

        // Saturate down from 3
        bus.enable = 1'b0; bus.mode = 2'b01; bus.up = 1'b0;
        do_load(8'd3);
        expect_out("sat_load", 8'd3, 1'b0, 1'b0);
        bus.enable = 1'b1;
        cyc(); expect_out("sat_dn2", 8'd2, 1'b0, 1'b0);
        cyc(); expect_out("sat_dn1", 8'd1, 1'b0, 1'b0);
        cyc(); expect_out("sat_dn0", 8'd0, 1'b0, 1'b0);
        cyc(); expect_out("sat_hold0a", 8'd0, 1'b1, 1'b0);
        cyc(); expect_out("sat_hold0b", 8'd0, 1'b1, 1'b0);
        bus.enable = 1'b0;
        cyc(); expect_out("sat_disabled", 8'd0, 1'b0, 1'b0);

        // Saturate up with count above limit
        bus.up = 1'b1; bus.limit = 8'd5;
        do_load(8'd7);
        bus.enable = 1'b1;
        cyc(); expect_out("sat_above", 8'd7, 1'b1, 1'b0);

        // Wrap boundaries
        bus.enable = 1'b0; bus.mode = 2'b00; bus.limit = 8'h0F;
        do_load(8'hF0);
        expect_out("wrap_ld_F0", 8'hF0, 1'b0, 1'b0);
        bus.enable = 1'b1;
        cyc(); expect_out("wrap_above", 8'h00, 1'b1, 1'b0);
        bus.enable = 1'b0; bus.limit = 8'hFF;
        do_load(8'hFF);
        bus.enable = 1'b1;
        cyc(); expect_out("wrap_ff", 8'h00, 1'b1, 1'b0);
        bus.limit = 8'h00;
        cyc(); expect_out("wrap_lim0a", 8'h00, 1'b1, 1'b0);
        cyc(); expect_out("wrap_lim0b", 8'h00, 1'b1, 1'b0);
        bus.up = 1'b0; bus.limit = 8'd5;
        cyc(); expect_out("wrap_dn_to_lim", 8'd5, 1'b1, 1'b0);
        bus.enable = 1'b0;
        do_load(8'h20);
        bus.enable = 1'b1;
        cyc(); expect_out("dn_above", 8'h1F, 1'b0, 1'b0);

        // Hold mode
        bus.mode = 2'b11;
        cyc(); expect_out("hold", 8'h1F, 1'b0, 1'b0);
        do_load(8'd9);
        expect_out("hold_load", 8'd9, 1'b0, 1'b0);

        // One-shot up to 3, with a start during the run
        bus.mode = 2'b10; bus.up = 1'b1; bus.limit = 8'd3; bus.enable = 1'b1;
        cyc(); expect_out("os_idle", 8'd9, 1'b0, 1'b0);
        bus.start = 1'b1;
        cyc(); expect_out("os_start", 8'd0, 1'b0, 1'b1);
        cyc(); expect_out("os_1_start_ignored", 8'd1, 1'b0, 1'b1);
        bus.start = 1'b0;
        cyc(); expect_out("os_2", 8'd2, 1'b0, 1'b1);
        cyc(); expect_out("os_3", 8'd3, 1'b0, 1'b1);
        cyc(); expect_out("os_term", 8'd3, 1'b1, 1'b0);
        cyc(); expect_out("os_done", 8'd3, 1'b0, 1'b0);

        // Load beats start in IDLE
        bus.load = 1'b1; bus.load_value = 8'h80; bus.start = 1'b1;
        cyc(); expect_out("ld_vs_start", 8'h80, 1'b0, 1'b0);
        bus.load = 1'b0; bus.start = 1'b0;
        cyc(); expect_out("ld_vs_start_idle", 8'h80, 1'b0, 1'b0);

        // Run paused by enable, load inside run keeps RUN
        bus.start = 1'b1;
        cyc(); expect_out("os2_start", 8'd0, 1'b0, 1'b1);
        bus.start = 1'b0; bus.enable = 1'b0;
        cyc(); expect_out("os2_pause", 8'd0, 1'b0, 1'b1);
        do_load(8'd2);
        expect_out("os2_load", 8'd2, 1'b0, 1'b1);
        bus.enable = 1'b1;
        cyc(); expect_out("os2_3", 8'd3, 1'b0, 1'b1);

        // Reset aborts a run at count 2
        bus.start = 1'b1;
        cyc(); cyc(); // terminal edge, then restart
        bus.start = 1'b0;
        cyc(); cyc();
        expect_out("os3_at2", 8'd2, 1'b0, 1'b1);
        reset = 1'b1;
        cyc(); expect_out("os3_reset", 8'd0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(); expect_out("os3_after_a", 8'd0, 1'b0, 1'b0);
        cyc(); expect_out("os3_after_b", 8'd0, 1'b0, 1'b0);

        // Leaving one-shot mode mid-run drops busy
        bus.start = 1'b1;
        cyc(); expect_out("os4_start", 8'd0, 1'b0, 1'b1);
        bus.start = 1'b0; bus.mode = 2'b00;
        cyc(); expect_out("os4_modechg", 8'd1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
